pipe_ctrl_unit: RTL
===================

Name: pipe_ctrl_unit

Overview:
Parametrised pipelined main-control unit for the 5-stage MIPS core.
- Decodes the ID-stage opcode.
- Carries the control bundle and the destination register through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards and inserts bubbles.
- Sits between the IF/ID register and the datapath; the PC, IF/ID, hazard and forwarding logic consume its stage outputs.

Parameters:
OP_W, 6, opcode width
REG_AW, 5, register-address width
ALUOP_W, 2, ALU-op field width
CNT_W, 32, stall-counter width (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
op_i  in  OP_W  ID opcode
rs_i  in  REG_AW  ID rs
rt_i  in  REG_AW  ID rt
rd_i  in  REG_AW  ID rd
id_flush_i  in  1  squash ID instruction
stall_o  out  1  hold PC and IF/ID
branch_o  out  1  ID beq, gated
jump_o  out  1  ID j, gated
illegal_o  out  1  ID opcode unknown
ex_alu_src_o  out  1  EX ALUSrc
ex_alu_op_o  out  ALUOP_W  EX ALUOp
ex_reg_write_o  out  1  EX RegWrite
ex_wr_reg_o  out  REG_AW  EX destination (RegDst applied)
mem_mem_read_o  out  1  MEM MemRead
mem_mem_write_o  out  1  MEM MemWrite
mem_reg_write_o  out  1  MEM RegWrite
mem_wr_reg_o  out  REG_AW  MEM destination
wb_reg_write_o  out  1  WB RegWrite
wb_mem_to_reg_o  out  1  WB MemtoReg
wb_wr_reg_o  out  REG_AW  WB destination

Behaviour:
- Interface: one clock clk_i; rst_i is synchronous, active-high.
- Decode (combinational, ID). Fields are RegDst/ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/Branch/Jump/ALUOp.
  - R-type 000000 = 1/0/0/1/0/0/0/0/10
  - addi 001000 = 0/1/0/1/0/0/0/0/00
  - lw 100011 = 0/1/1/1/1/0/0/0/00
  - sw 101011 = 0/1/0/0/0/1/0/0/00
  - beq 000100 = 0/0/0/0/0/0/1/0/01
  - j 000010 = 0/0/0/0/0/0/0/1/00
  - Any other opcode: all fields 0 (never X) and illegal_o=1.
- Destination: RegDst ? rd_i : rt_i. It is forced to 0 when RegWrite=0.
- Pipeline: every rising edge, ID->EX->MEM->WB registers advance; there is no enable on EX/MEM or MEM/WB. EX outputs appear 1 cycle after ID decode, MEM 2, WB 3.
- Bubble: ID/EX loads all-zero (dest 0) when stall_o | id_flush_i | illegal_o.
- Load-use stall: stall_o=1 if ID/EX MemRead=1, ex_wr_reg_o!=0, and ex_wr_reg_o==rs_i, or ex_wr_reg_o==rt_i where the ID opcode reads rt (R-type, sw, beq).
- Branch stall: ID opcode is beq and rs_i/rt_i (nonzero) matches either:
  - ex_wr_reg_o with ex_reg_write_o=1, or
  - mem_wr_reg_o with mem_mem_read_o=1.
  Result: lw->beq stalls 2 cycles; ALU op->beq stalls 1.
- Gating: branch_o = Branch & ~stall_o & ~id_flush_i. jump_o is gated the same way.
- id_flush_i together with a stall condition: the flush wins the bubble, and stall_o is still reported.
- Register $0 never creates a hazard.
- Reset: all stage registers 0, so every ex_/mem_/wb_ output is 0 the cycle after rst_i. Combinational ID outputs follow the inputs. Reset mid-stream drops all in-flight instructions.

Optional Feature:
STALL_CNT_EN
- Defined: adds port stall_cnt_o out CNT_W. It increments on each cycle with stall_o=1, saturates at all-ones, and clears on rst_i.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - packed struct ctrl_t for the control bundle.
- Sub-module pipe_ctrl_hazard: pure combinational stall detection.
- Decode and stage registers live in the top module.

Test Plan:
- rst_i high 2 cycles, then op=R-type rd=3 -> cycle+1 ex_wr_reg_o=3, ex_alu_op_o=10; cycle+3 wb_reg_write_o=1, wb_wr_reg_o=3; never stall_o.
- lw rt=5 then R-type rs=5 -> stall_o=1 for exactly 1 cycle; ID/EX bubble (ex_reg_write_o=0); R-type reaches EX on the next cycle.
- addi rt=7 then beq rs=7 -> 1 stall cycle, branch_o=0 during stall then 1. lw rt=7 then beq rt=7 -> 2 stall cycles.
- op=111111 -> illegal_o=1; next cycle all ex_ outputs 0. lw rt=0 then R-type rs=0 -> no stall.
- beq with id_flush_i=1 -> branch_o=0 and the bubble enters EX. rst_i asserted while lw in MEM -> all mem_/wb_ outputs 0 next cycle.
- STALL_CNT_EN defined: 3 load-use pairs -> stall_cnt_o=3. Force counter near all-ones -> holds at all-ones.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALU-op encodings and the control bundle for the pipelined main-control unit.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_hazard.sv
// Combinational load-use and branch-operand stall detection; register $0 never matches.
module pipe_ctrl_unit_hazard #(
    parameter int REG_AW = 5
) (
    input  logic              id_is_beq,
    input  logic              id_reads_rt,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_wr_reg,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_wr_reg,
    output logic              stall
);

    logic load_use;
    logic rs_dep;
    logic rt_dep;

    assign load_use = ex_mem_read && (ex_wr_reg != '0) &&
                      ((ex_wr_reg == rs) || (id_reads_rt && (ex_wr_reg == rt)));

    // beq resolves in ID, so it must wait for ALU results in EX and load data in MEM.
    assign rs_dep = (rs != '0) && ((ex_reg_write && (ex_wr_reg == rs)) ||
                                   (mem_mem_read && (mem_wr_reg == rs)));
    assign rt_dep = (rt != '0) && ((ex_reg_write && (ex_wr_reg == rt)) ||
                                   (mem_mem_read && (mem_wr_reg == rt)));

    assign stall = load_use || (id_is_beq && (rs_dep || rt_dep));

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS main control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazard bubbles.
// Optional STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [REG_AW-1:0]  rs_i,
    input  logic [REG_AW-1:0]  rt_i,
    input  logic [REG_AW-1:0]  rd_i,
    input  logic               id_flush_i,
    output logic               stall_o,
    output logic               branch_o,
    output logic               jump_o,
    output logic               illegal_o,
    output logic               ex_alu_src_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               ex_reg_write_o,
    output logic [REG_AW-1:0]  ex_wr_reg_o,
    output logic               mem_mem_read_o,
    output logic               mem_mem_write_o,
    output logic               mem_reg_write_o,
    output logic [REG_AW-1:0]  mem_wr_reg_o,
    output logic               wb_reg_write_o,
    output logic               wb_mem_to_reg_o,
`ifdef STALL_CNT_EN
    output logic [CNT_W-1:0]   stall_cnt_o,
`endif
    output logic [REG_AW-1:0]  wb_wr_reg_o
);

    ctrl_t             id_ctrl;
    logic              id_illegal;
    logic              id_reads_rt;
    logic [REG_AW-1:0] id_dst;
    logic              stall;

    ctrl_t             ex_ctrl,  mem_ctrl,  wb_ctrl;
    logic [REG_AW-1:0] ex_dst,   mem_dst,   wb_dst;

    always_comb begin
        id_ctrl     = '0;
        id_illegal  = 1'b0;
        id_reads_rt = 1'b0;
        case (op_i)
            OP_W'(OP_RTYPE): begin
                id_ctrl.reg_dst   = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_op    = ALUOP_FUNCT;
                id_reads_rt       = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_W'(OP_LW): begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_W'(OP_SW): begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.mem_write = 1'b1;
                id_ctrl.alu_op    = ALUOP_ADD;
                id_reads_rt       = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                id_ctrl.branch = 1'b1;
                id_ctrl.alu_op = ALUOP_SUB;
                id_reads_rt    = 1'b1;
            end
            OP_W'(OP_J): begin
                id_ctrl.jump = 1'b1;
            end
            default: id_illegal = 1'b1;
        endcase
    end

    // A zero destination on non-writing instructions keeps them out of every hazard compare.
    assign id_dst = !id_ctrl.reg_write ? '0 : (id_ctrl.reg_dst ? rd_i : rt_i);

    pipe_ctrl_unit_hazard #(.REG_AW(REG_AW)) u_hazard (
        .id_is_beq    (id_ctrl.branch),
        .id_reads_rt  (id_reads_rt),
        .rs           (rs_i),
        .rt           (rt_i),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_reg_write (ex_ctrl.reg_write),
        .ex_wr_reg    (ex_dst),
        .mem_mem_read (mem_ctrl.mem_read),
        .mem_wr_reg   (mem_dst),
        .stall        (stall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl  <= '0;
            ex_dst   <= '0;
            mem_ctrl <= '0;
            mem_dst  <= '0;
            wb_ctrl  <= '0;
            wb_dst   <= '0;
        end else begin
            if (stall || id_flush_i || id_illegal) begin
                ex_ctrl <= '0;
                ex_dst  <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_dst  <= id_dst;
            end
            mem_ctrl <= ex_ctrl;
            mem_dst  <= ex_dst;
            wb_ctrl  <= mem_ctrl;
            wb_dst   <= mem_dst;
        end
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign stall_cnt_o = stall_cnt;
`endif

    assign stall_o         = stall;
    assign branch_o        = id_ctrl.branch && !stall && !id_flush_i;
    assign jump_o          = id_ctrl.jump && !stall && !id_flush_i;
    assign illegal_o       = id_illegal;
    assign ex_alu_src_o    = ex_ctrl.alu_src;
    assign ex_alu_op_o     = ALUOP_W'(ex_ctrl.alu_op);
    assign ex_reg_write_o  = ex_ctrl.reg_write;
    assign ex_wr_reg_o     = ex_dst;
    assign mem_mem_read_o  = mem_ctrl.mem_read;
    assign mem_mem_write_o = mem_ctrl.mem_write;
    assign mem_reg_write_o = mem_ctrl.reg_write;
    assign mem_wr_reg_o    = mem_dst;
    assign wb_reg_write_o  = wb_ctrl.reg_write;
    assign wb_mem_to_reg_o = wb_ctrl.mem_to_reg;
    assign wb_wr_reg_o     = wb_dst;

endmodule
